// File: rtl/plab2_proc_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes
// and the control FSM state encoding.
package plab2_proc_muldiv_iter_pkg;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic fn_is_signed(input logic [2:0] fn);
        return (fn == FN_DIV) || (fn == FN_REM);
    endfunction

endpackage

// File: rtl/plab2_proc_muldiv_iter_ctrl.sv
// Control for the iterative mul/div unit: IDLE/CALC/DONE FSM, step counter,
// val/rdy handshakes and the load/step/finish strobes for the datapath.
module plab2_proc_muldiv_iter_ctrl
    import plab2_proc_muldiv_iter_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic req_val,
    output logic req_rdy,
    output logic resp_val,
    input  logic resp_rdy,
    output logic load,
    output logic step,
    output logic finish
);

    localparam int CW = $clog2(p_nbits);

    state_t        state;
    logic [CW-1:0] count;
    logic          idle_q;
    logic          calc_q;
    logic          last;

    assign last    = (count == CW'(p_nbits - 1));
    assign req_rdy = idle_q && !reset;
    assign load    = req_val && req_rdy;
    assign step    = calc_q;
    assign finish  = calc_q && last;

    // The counter only advances inside CALC, so it holds at p_nbits-1 after the final step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            idle_q   <= 1'b1;
            calc_q   <= 1'b0;
            resp_val <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_val) begin
                        state  <= ST_CALC;
                        count  <= '0;
                        idle_q <= 1'b0;
                        calc_q <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (last) begin
                        state    <= ST_DONE;
                        calc_q   <= 1'b0;
                        resp_val <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_rdy) begin
                        state    <= ST_IDLE;
                        idle_q   <= 1'b1;
                        resp_val <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    idle_q   <= 1'b1;
                    calc_q   <= 1'b0;
                    resp_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/plab2_proc_muldiv_iter.sv
// Iterative multiply/divide unit: one result bit per cycle, shift-add multiply
// and restoring division on magnitudes with sign fixup on the final step.
module plab2_proc_muldiv_iter
    import plab2_proc_muldiv_iter_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2:0]         req_fn,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_data
);

    localparam int N = p_nbits;

    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic sgn);
        return (sgn && v[N-1]) ? -v : v;
    endfunction

    function automatic logic [N-1:0] apply_sign(input logic [N-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic load;
    logic step;
    logic finish;

    plab2_proc_muldiv_iter_ctrl #(
        .p_nbits (p_nbits)
    ) ctrl (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .load     (load),
        .step     (step),
        .finish   (finish)
    );

    // a_q: multiplicand (MUL) or dividend shifting out / quotient shifting in (divide).
    // b_q: multiplier (MUL) or divisor magnitude. acc_q: product or partial remainder.
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] acc_q;
    logic [2:0]   fn_q;
    logic         neg_quo_q;
    logic         neg_rem_q;
    logic         div0_q;

    logic         req_signed;
    logic [N:0]   rem_sh;
    logic [N:0]   diff;
    logic         qbit;
    logic [N-1:0] rem_nxt;
    logic [N-1:0] quo_nxt;
    logic [N-1:0] prod_nxt;
    logic [N-1:0] result;

    assign req_signed = fn_is_signed(req_fn);

    // rem_sh[N] set means the shifted remainder already exceeds any N-bit divisor.
    always_comb begin
        rem_sh   = {acc_q, a_q[N-1]};
        diff     = rem_sh - {1'b0, b_q};
        qbit     = rem_sh[N] | ~diff[N];
        rem_nxt  = qbit ? diff[N-1:0] : rem_sh[N-1:0];
        quo_nxt  = {a_q[N-2:0], qbit};
        prod_nxt = acc_q + (b_q[0] ? a_q : '0);
    end

    always_comb begin
        result = '0;
        case (fn_q)
            FN_MUL:  result = prod_nxt;
            FN_DIV:  result = div0_q ? '1 : apply_sign(quo_nxt, neg_quo_q);
            FN_DIVU: result = quo_nxt;
            FN_REM:  result = apply_sign(rem_nxt, neg_rem_q);
            FN_REMU: result = rem_nxt;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            fn_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            resp_data <= '0;
        end else if (load) begin
            a_q       <= (req_fn == FN_MUL) ? req_a : magnitude(req_a, req_signed);
            b_q       <= (req_fn == FN_MUL) ? req_b : magnitude(req_b, req_signed);
            acc_q     <= '0;
            fn_q      <= req_fn;
            neg_quo_q <= req_signed && (req_a[N-1] ^ req_b[N-1]);
            neg_rem_q <= req_signed && req_a[N-1];
            div0_q    <= (req_b == '0);
        end else if (step) begin
            if (fn_q == FN_MUL) begin
                acc_q <= prod_nxt;
                a_q   <= {a_q[N-2:0], 1'b0};
                b_q   <= {1'b0, b_q[N-1:1]};
            end else begin
                acc_q <= rem_nxt;
                a_q   <= quo_nxt;
            end
            if (finish) begin
                resp_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_plab2_proc_muldiv_iter.sv
// Bench for the iterative mul/div unit: a 32-bit and an 8-bit instance driven
// from a vector table plus backpressure, throughput and mid-operation reset sequences.
module tb_plab2_proc_muldiv_iter;
    import plab2_proc_muldiv_iter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_val = 1'b0;
    logic        resp_rdy = 1'b1;
    logic        sel8 = 1'b0;
    logic [2:0]  req_fn = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;

    logic        val32_in, val8_in;
    logic        rdy32, rdy8, rv32, rv8;
    logic [31:0] rd32;
    logic [7:0]  rd8;
    logic        cur_rdy, cur_val;
    logic [31:0] cur_data;

    assign val32_in = req_val & ~sel8;
    assign val8_in  = req_val & sel8;
    assign cur_rdy  = sel8 ? rdy8 : rdy32;
    assign cur_val  = sel8 ? rv8 : rv32;
    assign cur_data = sel8 ? {24'h0, rd8} : rd32;

    plab2_proc_muldiv_iter #(.p_nbits(32)) dut32 (
        .clk       (clk),
        .reset     (reset),
        .req_val   (val32_in),
        .req_rdy   (rdy32),
        .req_fn    (req_fn),
        .req_a     (req_a),
        .req_b     (req_b),
        .resp_val  (rv32),
        .resp_rdy  (resp_rdy),
        .resp_data (rd32)
    );

    plab2_proc_muldiv_iter #(.p_nbits(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .req_val   (val8_in),
        .req_rdy   (rdy8),
        .req_fn    (req_fn),
        .req_a     (req_a[7:0]),
        .req_b     (req_b[7:0]),
        .resp_val  (rv8),
        .resp_rdy  (resp_rdy),
        .resp_data (rd8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cyc = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        bit          w8;
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        int w = 0;
        while (!cur_rdy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cur_rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: req_rdy got 0, required 1");
            return;
        end
        req_fn  = fn;
        req_a   = a;
        req_b   = b;
        req_val = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        req_val = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_resp(input string name, input int exp_lat);
        int lat = 0;
        logic [31:0] e;
        while (!cur_val && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_sb: got empty scoreboard, required one entry", name);
            return;
        end
        e = exp_q.pop_front();
        check(name, {32'h0, cur_data}, {32'h0, e});
    endtask

    initial begin
        int c0;
        int hs_cyc;
        int seen;

        vecs.push_back('{"mul_7xm3",    1'b0, FN_MUL,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB});
        vecs.push_back('{"mul_ovf",     1'b0, FN_MUL,  32'h00010000, 32'h00010000, 32'h00000000});
        vecs.push_back('{"mul_plain",   1'b0, FN_MUL,  32'd12345,    32'd678,      32'h007FB6F6});
        vecs.push_back('{"div_m7_2",    1'b0, FN_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
        vecs.push_back('{"rem_m7_2",    1'b0, FN_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
        vecs.push_back('{"divu_big",    1'b0, FN_DIVU, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC});
        vecs.push_back('{"div_100_m7",  1'b0, FN_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2});
        vecs.push_back('{"rem_100_m7",  1'b0, FN_REM,  32'd100,      32'hFFFFFFF9, 32'd2});
        vecs.push_back('{"rem_m100_7",  1'b0, FN_REM,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE});
        vecs.push_back('{"divu_by0",    1'b0, FN_DIVU, 32'h1234,     32'd0,        32'hFFFFFFFF});
        vecs.push_back('{"remu_by0",    1'b0, FN_REMU, 32'h1234,     32'd0,        32'h1234});
        vecs.push_back('{"div_neg_by0", 1'b0, FN_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF});
        vecs.push_back('{"rem_neg_by0", 1'b0, FN_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9});
        vecs.push_back('{"div_sovf",    1'b0, FN_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{"rem_sovf",    1'b0, FN_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{"fn_rsvd",     1'b0, 3'd5,    32'd9,        32'd3,        32'h00000000});
        vecs.push_back('{"w8_divu",     1'b1, FN_DIVU, 32'd200,      32'd7,        32'd28});
        vecs.push_back('{"w8_remu",     1'b1, FN_REMU, 32'd200,      32'd7,        32'd4});
        vecs.push_back('{"w8_mul",      1'b1, FN_MUL,  32'hFF,       32'hFF,       32'h01});
        vecs.push_back('{"w8_sovf",     1'b1, FN_DIV,  32'h80,       32'hFF,       32'h80});

        @(negedge clk);
        check("rst_rdy32",  64'(rdy32), 64'd0);
        check("rst_rdy8",   64'(rdy8),  64'd0);
        check("rst_val32",  64'(rv32),  64'd0);
        check("rst_data32", 64'(rd32),  64'd0);
        check("rst_data8",  64'(rd8),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rdy32", 64'(rdy32), 64'd1);
        check("post_rst_rdy8",  64'(rdy8),  64'd1);

        foreach (vecs[i]) begin
            sel8 = vecs[i].w8;
            issue(vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            wait_resp(vecs[i].name, vecs[i].w8 ? 8 : 32);
        end
        sel8 = 1'b0;

        // Back-to-back throughput with resp_rdy held high.
        issue(FN_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
        c0 = acc_cyc;
        wait_resp("tput_a", 32);
        issue(FN_MUL, 32'd6, 32'd7, 32'd42, 1'b1);
        check("tput_gap", 64'(acc_cyc - c0), 64'd34);
        wait_resp("tput_b", 32);

        // Backpressure: result held while resp_rdy is low.
        @(negedge clk);
        resp_rdy = 1'b0;
        issue(FN_MUL, 32'd3, 32'd5, 32'd15, 1'b1);
        wait_resp("bp_data", 32);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_data", 64'(rd32),  64'd15);
            check("bp_hold_val",  64'(rv32),  64'd1);
            check("bp_hold_rdy",  64'(rdy32), 64'd0);
            @(negedge clk);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hs_cyc = cyc;
        check("bp_release_rdy", 64'(rdy32), 64'd1);
        issue(FN_REMU, 32'd50, 32'd8, 32'd2, 1'b1);
        check("bp_accept_cycle", 64'(acc_cyc - hs_cyc), 64'd1);
        wait_resp("bp_next", 32);

        // Reset in the middle of CALC aborts the operation without a response.
        @(negedge clk);
        issue(FN_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_rdy",  64'(rdy32), 64'd0);
        check("abort_val",  64'(rv32),  64'd0);
        check("abort_data", 64'(rd32),  64'd0);
        @(negedge clk);
        check("abort_rdy_hold", 64'(rdy32), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_rdy_after", 64'(rdy32), 64'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (rv32) seen++;
            @(negedge clk);
        end
        check("abort_no_resp", 64'(seen), 64'd0);
        issue(FN_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_resp("after_abort", 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
